spi_master_gen: RTL
===================

// Module: spi_master_gen
// PURPOSE
//  Parametrised SPI master, successor to the fixed 8-bit display SPI engine. Serialises DATA_W-bit
//  words on MOSI with a programmable SCK divider, CPOL/CPHA mode, bit order and NUM_CS chip selects.
//  Carries a display data/command (DC) flag per word. Supports CS held across multi-word bursts.
//  Sits between the display/peripheral controllers and the board SPI pins; valid/ready on the host side.
// PARAMETERS
//  DATA_W    8  bits per word (4..32)
//  CLK_DIV   5  clk cycles per SCK half-period (>=2)
//  NUM_CS    1  number of active-low chip selects (1..8)
//  CPOL      0  SCK idle level
//  CPHA      0  0: sample on leading edge, 1: sample on trailing edge
//  LSB_FIRST 0  0: MSB shifted first, 1: LSB first
//  GAP_HALF  2  SCK half-periods of CS-deasserted gap after a frame (>=1)
// PORTS
//  clk       in   1                 system clock, all logic on posedge
//  reset     in   1                 synchronous, active-high
//  tx_valid  in   1                 host word available
//  tx_ready  out  1                 engine accepts a word this cycle
//  tx_data   in   DATA_W            word to send
//  tx_dc     in   1                 DC level for this word
//  tx_cs_sel in   $clog2(NUM_CS)+1  chip-select index
//  tx_keep   in   1                 1: keep CS asserted after this word (burst)
//  tx_done   out  1                 1-clk pulse at end of each word
//  busy      out  1                 high whenever state != IDLE
//  sck       out  1                 SPI clock
//  mosi      out  1                 SPI data out
//  cs_n      out  NUM_CS            active-low chip selects
//  dc        out  1                 data/command, valid while any cs_n low, else 0
// BEHAVIOUR
//  Reset (sync, high): state=IDLE, sck=CPOL, mosi=0, cs_n=all 1, dc=0, tx_done=0, busy=0,
//   tx_ready=0 during reset and 1 from the first cycle after. Reset mid-frame aborts immediately:
//   cs_n all 1 on the next edge, no tx_done.
//  Timebase: half-period tick every CLK_DIV clk cycles, counter runs only when state != IDLE/KEEP.
//  Handshake: accept when tx_valid && tx_ready; tx_data/dc/cs_sel/keep latched that cycle;
//   tx_ready = (state==IDLE || state==KEEP) && !reset.
//  FSM: IDLE -accept-> SETUP (cs_n[sel]=0, dc driven, 1 half-period; CPHA=0 puts bit0 on mosi)
//   -> SHIFT (2*DATA_W half-periods; sck toggles each tick; CPHA=0: mosi changes on trailing edge,
//   CPHA=1: on leading edge) -> HOLD (1 half-period, sck=CPOL, CS held; tx_done pulses on exit)
//   -> keep ? KEEP : GAP (GAP_HALF half-periods, cs_n all 1) -> IDLE.
//  KEEP: CS and dc held, sck=CPOL; accept -> SHIFT directly (no SETUP), new dc applied, new
//   cs_sel ignored; tx_keep of new word governs next exit. No new word: wait indefinitely.
//  Bit order: LSB_FIRST selects shift direction; exactly DATA_W bits per word.
//  tx_cs_sel >= NUM_CS: frame timed normally, no cs_n asserted, dc stays 0, tx_done still pulses.
//  tx_valid during SETUP/SHIFT/HOLD/GAP ignored (tx_ready=0); host must hold it.
//  Throughput (no keep): 1 + 2*DATA_W + 1 + GAP_HALF half-periods + 1 clk per word.
// CONFIGURATION
//  SPI_MASTER_GEN_MISO_EN defined: adds ports miso (in,1), rx_data (out,DATA_W), rx_valid (out,1).
//   miso sampled on the sample edge through a 2-flop synchroniser, shifted in the configured bit
//   order; rx_data updated and rx_valid pulsed in the same cycle as tx_done. Reset: rx_data=0,
//   rx_valid=0.
//  Not defined: ports absent, no receive logic; transmit behaviour identical.
// STRUCTURE
//  spi_pkg.svh: state encoding localparams (IDLE,SETUP,SHIFT,HOLD,KEEP,GAP), mode constants,
//   CLK_DIV/DATA_W range checks.
//  Sub-module spi_clk_div: half-period tick generator (enable, clear, tick); FSM and shifter in top.
// TESTING
//  Mode 0, DATA_W=8, CLK_DIV=5, send 0xA5 dc=1 cs_sel=0 -> mosi 1,0,1,0,0,1,0,1 stable at each
//   rising sck; cs_n[0] low for 18 half-periods; dc=1 throughout; one tx_done.
//  CPOL=1 CPHA=1 LSB_FIRST=1, send 0x3C -> sck idles 1, bits 0,0,1,1,1,1,0,0 sampled on rising edge.
//  Burst: 3 words 0x01,0x02,0x03 with keep=1,1,0 -> cs_n low continuous from first SETUP to last
//   HOLD, 3 tx_done pulses, GAP only after third word.
//  Reset asserted mid-SHIFT of 0xFF -> next clk cs_n=all 1, sck=CPOL, mosi=0, no tx_done;
//   new word after reset transmits correctly.
//  NUM_CS=4, cs_sel=2 then cs_sel=5 -> first asserts only cs_n[2]; second asserts none, dc=0,
//   tx_done pulses.
//  MISO_EN: loop mosi->miso, send 0x5A and 0xC3 -> rx_data=0x5A then 0xC3 with rx_valid on tx_done.

Source files
------------

// File: rtl/spi_master_gen_pkg.sv
// Shared types and helpers for the parametrised SPI master.
// Optional receive path: define SPI_MASTER_GEN_MISO_EN.
package spi_master_gen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_KEEP,
    ST_GAP
  } state_t;

  localparam logic [1:0] SPI_MODE_0 = 2'b00;
  localparam logic [1:0] SPI_MODE_1 = 2'b01;
  localparam logic [1:0] SPI_MODE_2 = 2'b10;
  localparam logic [1:0] SPI_MODE_3 = 2'b11;

  function automatic bit params_ok(
    input int data_w,
    input int clk_div,
    input int num_cs,
    input int gap_half
  );
    return data_w >= 4 && data_w <= 32 &&
           clk_div >= 2 &&
           num_cs >= 1 && num_cs <= 8 &&
           gap_half >= 1;
  endfunction

endpackage

// File: rtl/spi_master_gen_clk_div.sv
// Half-period tick generator for the SPI master.
// Counts only while enabled; clear or disable returns it to zero.
module spi_clk_div
  import spi_master_gen_pkg::*;
#(
  parameter int DIV = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(DIV);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || clr || !en) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_gen.sv
// Parametrised SPI master with CS bursts and a DC flag per word.
// Optional MISO receive path: define SPI_MASTER_GEN_MISO_EN.
module spi_master_gen
  import spi_master_gen_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 5,
  parameter int NUM_CS    = 1,
  parameter bit CPOL      = 1'b0,
  parameter bit CPHA      = 1'b0,
  parameter bit LSB_FIRST = 1'b0,
  parameter int GAP_HALF  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  input  logic [DATA_W-1:0]       tx_data,
  input  logic                    tx_dc,
  input  logic [$clog2(NUM_CS):0] tx_cs_sel,
  input  logic                    tx_keep,
  output logic                    tx_done,
  output logic                    busy,
  output logic                    sck,
  output logic                    mosi,
  output logic [NUM_CS-1:0]       cs_n,
  output logic                    dc
`ifdef SPI_MASTER_GEN_MISO_EN
  ,
  input  logic                    miso,
  output logic [DATA_W-1:0]       rx_data,
  output logic                    rx_valid
`endif
);

  localparam int SW  = $clog2(NUM_CS) + 1;
  localparam int HCW = $clog2(2 * DATA_W);
  localparam int GCW = $clog2(GAP_HALF) + 1;

  if (!params_ok(DATA_W, CLK_DIV, NUM_CS, GAP_HALF)) begin : g_param_err
    $error("spi_master_gen: parameter out of range");
  end

  state_t            state;
  logic [DATA_W-1:0] sr;
  logic [HCW-1:0]    hc;
  logic [GCW-1:0]    gc;
  logic [SW-1:0]     sel;
  logic              keep_l;
  logic              tick;
  logic              en;
  logic              accept;
  logic              lead;
  logic              trail;

  function automatic logic sel_ok(input logic [SW-1:0] s);
    return int'(s) < NUM_CS;
  endfunction

  function automatic logic [NUM_CS-1:0] cs_vec(input logic [SW-1:0] s);
    return sel_ok(s) ? ~(NUM_CS'(1) << s) : '1;
  endfunction

  function automatic logic first_bit(input logic [DATA_W-1:0] v);
    return LSB_FIRST ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] nxt(input logic [DATA_W-1:0] v);
    return LSB_FIRST ? (v >> 1) : (v << 1);
  endfunction

  assign tx_ready = (state == ST_IDLE || state == ST_KEEP) && !reset;
  assign accept   = tx_valid && tx_ready;
  assign en       = !(state == ST_IDLE || state == ST_KEEP);
  assign lead     = tick && state == ST_SHIFT && !hc[0];
  assign trail    = tick && state == ST_SHIFT && hc[0];

  spi_clk_div #(
    .DIV(CLK_DIV)
  ) u_div (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .clr  (accept),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      sck     <= CPOL;
      mosi    <= 1'b0;
      cs_n    <= '1;
      dc      <= 1'b0;
      tx_done <= 1'b0;
      busy    <= 1'b0;
      sr      <= '0;
      hc      <= '0;
      gc      <= '0;
      sel     <= '0;
      keep_l  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      unique case (state)
        ST_IDLE, ST_KEEP: begin
          if (accept) begin
            keep_l <= tx_keep;
            hc     <= '0;
            busy   <= 1'b1;
            if (CPHA) begin
              sr <= tx_data;
            end else begin
              mosi <= first_bit(tx_data);
              sr   <= nxt(tx_data);
            end
            // Within a burst the original chip select stays in force
            if (state == ST_IDLE) begin
              sel   <= tx_cs_sel;
              cs_n  <= cs_vec(tx_cs_sel);
              dc    <= sel_ok(tx_cs_sel) && tx_dc;
              state <= ST_SETUP;
            end else begin
              dc    <= sel_ok(sel) && tx_dc;
              state <= ST_SHIFT;
            end
          end
        end
        ST_SETUP: begin
          if (tick) state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (tick) begin
            sck <= ~sck;
            hc  <= hc + 1'b1;
            if ((CPHA && lead) || (!CPHA && trail)) begin
              mosi <= first_bit(sr);
              sr   <= nxt(sr);
            end
            if (hc == HCW'(2 * DATA_W - 1)) state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (tick) begin
            tx_done <= 1'b1;
            mosi    <= 1'b0;
            sck     <= CPOL;
            if (keep_l) begin
              state <= ST_KEEP;
            end else begin
              state <= ST_GAP;
              gc    <= '0;
              cs_n  <= '1;
              dc    <= 1'b0;
            end
          end
        end
        ST_GAP: begin
          if (tick) begin
            gc <= gc + 1'b1;
            if (gc == GCW'(GAP_HALF - 1)) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef SPI_MASTER_GEN_MISO_EN
  logic              m1;
  logic              m2;
  logic [DATA_W-1:0] rx_sr;
  logic              samp;

  assign samp = CPHA ? trail : lead;

  always_ff @(posedge clk) begin
    if (reset) begin
      m1       <= 1'b0;
      m2       <= 1'b0;
      rx_sr    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
    end else begin
      m1       <= miso;
      m2       <= m1;
      rx_valid <= 1'b0;
      if (samp) begin
        rx_sr <= LSB_FIRST ? {m2, rx_sr[DATA_W-1:1]}
                           : {rx_sr[DATA_W-2:0], m2};
      end
      if (state == ST_HOLD && tick) begin
        rx_data  <= rx_sr;
        rx_valid <= 1'b1;
      end
    end
  end
`endif

endmodule
